// File: rtl/fpu_result_stage_pkg.sv
// Shared FP16 result-path types. The bundled result struct carries a tag whose
// width comes from FPU_TAGW, so all users agree on one layout.
`ifndef FPU_TAGW
`define FPU_TAGW 4
`endif

package fpu_lib;

  localparam int FPU_TAGW = `FPU_TAGW;

  typedef logic [15:0] fp16_t;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } condCode_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } opStatusFlag_t;

  typedef struct packed {
    fp16_t                 result;
    condCode_t             cond;
    opStatusFlag_t         flags;
    logic [`FPU_TAGW-1:0]  tag;
  } fpu_result_t;

endpackage

// File: rtl/fpu_result_stage_fifo.sv
// Generic valid/ready register FIFO. Output is always registered (no fall-through)
// and reads as zero while empty.
module fpuResultFifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             accept,
  output logic             retire
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // in_ready depends only on the registered count, never on out_ready.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (retire) rd_ptr <= rd_ptr + PW'(1);
      case ({accept, retire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_result_stage.sv
// Writeback stage behind the FP16 add/sub datapath: buffers results in order and
// keeps the sticky exception flags, last condition codes and retired-result count.
module fpu_result_stage
  import fpu_lib::*;
#(
  parameter int DEPTH = 2,
  parameter int TAGW  = FPU_TAGW,
  parameter int CNTW  = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  fp16_t           in_result,
  input  condCode_t       in_cond,
  input  opStatusFlag_t   in_flags,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output fp16_t           out_result,
  output condCode_t       out_cond,
  output opStatusFlag_t   out_flags,
  output logic [TAGW-1:0] out_tag,
  input  logic            flags_clr,
  output opStatusFlag_t   sticky_flags,
  output condCode_t       last_cond,
  output logic [CNTW-1:0] retired_cnt
);

  // Same field order as fpu_result_t, but sized from TAGW so overrides stay consistent.
  localparam int RW = $bits(fp16_t) + $bits(condCode_t) + $bits(opStatusFlag_t) + TAGW;

  logic [RW-1:0] fifo_in;
  logic [RW-1:0] fifo_out;
  logic          accept;
  logic          retire;

  assign fifo_in = {in_result, in_cond, in_flags, in_tag};
  assign {out_result, out_cond, out_flags, out_tag} = fifo_out;

  fpuResultFifo #(.DEPTH(DEPTH), .WIDTH(RW)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (fifo_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (fifo_out),
    .accept    (accept),
    .retire    (retire)
  );

  // A clear in the same cycle as an accept still keeps the new op's flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sticky_flags <= '0;
      last_cond    <= '0;
      retired_cnt  <= '0;
    end else begin
      sticky_flags <= opStatusFlag_t'((flags_clr ? '0 : sticky_flags) | (accept ? in_flags : '0));
      if (accept) last_cond <= in_cond;
      if (retire) retired_cnt <= retired_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_fpu_result_stage.sv
// Self-checking bench: a queue-based model of the result stage, directed scenarios
// followed by randomized traffic, with a narrow-counter copy to exercise wrap.
module tb_fpu_result_stage;
  import fpu_lib::*;

  localparam int DEPTH = 2;
  localparam int TAGW  = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  fp16_t         in_result = '0;
  condCode_t     in_cond = '0;
  opStatusFlag_t in_flags = '0;
  logic [3:0]    in_tag = '0;
  logic          out_ready = 1'b0;
  logic          flags_clr = 1'b0;

  logic          in_ready, out_valid;
  fp16_t         out_result;
  condCode_t     out_cond, last_cond;
  opStatusFlag_t out_flags, sticky_flags;
  logic [3:0]    out_tag;
  logic [15:0]   retired_cnt;

  logic          in_ready4, out_valid4;
  fp16_t         out_result4;
  condCode_t     out_cond4, last_cond4;
  opStatusFlag_t out_flags4, sticky_flags4;
  logic [3:0]    out_tag4;
  logic [3:0]    retired_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fpu_result_stage #(.DEPTH(DEPTH), .TAGW(TAGW), .CNTW(16)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_cond(in_cond), .in_flags(in_flags), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_cond(out_cond), .out_flags(out_flags), .out_tag(out_tag),
    .flags_clr(flags_clr), .sticky_flags(sticky_flags), .last_cond(last_cond),
    .retired_cnt(retired_cnt)
  );

  fpu_result_stage #(.DEPTH(DEPTH), .TAGW(TAGW), .CNTW(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_result(in_result), .in_cond(in_cond), .in_flags(in_flags), .in_tag(in_tag),
    .out_valid(out_valid4), .out_ready(out_ready), .out_result(out_result4),
    .out_cond(out_cond4), .out_flags(out_flags4), .out_tag(out_tag4),
    .flags_clr(flags_clr), .sticky_flags(sticky_flags4), .last_cond(last_cond4),
    .retired_cnt(retired_cnt4)
  );

  typedef struct {
    logic [15:0] result;
    logic [3:0]  cond;
    logic [3:0]  flags;
    logic [3:0]  tag;
  } entry_t;

  entry_t      q[$];
  logic [3:0]  m_sticky = '0;
  logic [3:0]  m_last = '0;
  int unsigned m_retired = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    logic        ev;
    logic [15:0] er;
    logic [3:0]  ec, ef, et;
    ev = (q.size() > 0);
    er = ev ? q[0].result : 16'h0;
    ec = ev ? q[0].cond : 4'h0;
    ef = ev ? q[0].flags : 4'h0;
    et = ev ? q[0].tag : 4'h0;
    check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(ev));
    check("out_result", 32'(out_result), 32'(er));
    check("out_cond", 32'(out_cond), 32'(ec));
    check("out_flags", 32'(out_flags), 32'(ef));
    check("out_tag", 32'(out_tag), 32'(et));
    check("sticky_flags", 32'(sticky_flags), 32'(m_sticky));
    check("last_cond", 32'(last_cond), 32'(m_last));
    check("retired_cnt", 32'(retired_cnt), m_retired % 65536);
    check("in_ready4", 32'(in_ready4), 32'(q.size() < DEPTH));
    check("out_valid4", 32'(out_valid4), 32'(ev));
    check("out_data4", {out_result4, out_cond4, out_flags4, out_tag4, 4'h0},
          {er, ec, ef, et, 4'h0});
    check("sticky4_last4", {24'h0, sticky_flags4, last_cond4}, {24'h0, m_sticky, m_last});
    check("retired_cnt4", 32'(retired_cnt4), m_retired % 16);
  endtask

  // One clock of traffic: compare on the falling edge, drive, then advance the model.
  task automatic apply_stimulus(input bit v, input logic [15:0] r, input logic [3:0] c,
                                input logic [3:0] f, input logic [3:0] t,
                                input bit ordy, input bit clr);
    bit acc, ret;
    @(negedge clock);
    check_output();
    in_valid  = v;
    in_result = r;
    in_cond   = c;
    in_flags  = f;
    in_tag    = t;
    out_ready = ordy;
    flags_clr = clr;
    acc = v && (q.size() < DEPTH);
    ret = ordy && (q.size() > 0);
    @(posedge clock);
    #1;
    if (ret) begin
      void'(q.pop_front());
      m_retired++;
    end
    m_sticky = (clr ? 4'h0 : m_sticky) | (acc ? f : 4'h0);
    if (acc) begin
      m_last = c;
      q.push_back('{result: r, cond: c, flags: f, tag: t});
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flags_clr = 1'b0;
    #1;
    q.delete();
    m_sticky  = '0;
    m_last    = '0;
    m_retired = 0;
    check_output();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sticky", 32'(sticky_flags), 32'd0);
    check("reset_retired", 32'(retired_cnt), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Single op: 1.0 appears on the output the cycle after acceptance.
    apply_stimulus(1, 16'h3C00, 4'h0, 4'h0, 4'd3, 1, 0);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_result", 32'(out_result), 32'h3C00);
    check("single_tag", 32'(out_tag), 32'd3);
    apply_stimulus(0, 16'h0, 4'h0, 4'h0, 4'd0, 1, 0);
    check("single_retired", 32'(retired_cnt), 32'd1);

    // Backpressure and ordering.
    do_reset();
    apply_stimulus(1, 16'h1111, 4'h1, 4'h0, 4'd1, 0, 0);
    apply_stimulus(1, 16'h2222, 4'h2, 4'h0, 4'd2, 0, 0);
    check("bp_full", 32'(in_ready), 32'd0);
    apply_stimulus(1, 16'h3333, 4'h3, 4'h0, 4'd3, 0, 0);
    check("bp_head1", 32'(out_tag), 32'd1);
    apply_stimulus(1, 16'h3333, 4'h3, 4'h0, 4'd3, 1, 0);
    check("bp_head2", 32'(out_tag), 32'd2);
    apply_stimulus(1, 16'h3333, 4'h3, 4'h0, 4'd3, 1, 0);
    check("bp_head3", 32'(out_tag), 32'd3);
    check("bp_result3", 32'(out_result), 32'h3333);
    apply_stimulus(0, 16'h0, 4'h0, 4'h0, 4'd0, 1, 0);
    check("bp_empty", 32'(out_valid), 32'd0);

    // Sticky flags: overflow then inexact, then clear together with underflow.
    do_reset();
    apply_stimulus(1, 16'h7BFF, 4'h1, 4'b0100, 4'd5, 1, 0);
    apply_stimulus(1, 16'h3555, 4'h2, 4'b0001, 4'd6, 1, 0);
    check("sticky_ovf_inx", 32'(sticky_flags), 32'b0101);
    apply_stimulus(1, 16'h0001, 4'h4, 4'b0010, 4'd7, 1, 1);
    check("sticky_clr_unf", 32'(sticky_flags), 32'b0010);
    check("last_cond_lit", 32'(last_cond), 32'h4);
    apply_stimulus(0, 16'h0, 4'h0, 4'h0, 4'd0, 1, 1);
    check("sticky_cleared", 32'(sticky_flags), 32'b0000);
    check("last_cond_kept", 32'(last_cond), 32'h4);

    // Streaming 100 back-to-back ops.
    do_reset();
    for (int i = 0; i < 100; i++)
      apply_stimulus(1, 16'($urandom), 4'($urandom), 4'h0, 4'(i), 1, 0);
    apply_stimulus(0, 16'h0, 4'h0, 4'h0, 4'd0, 1, 0);
    check("stream_retired", 32'(retired_cnt), 32'd100);
    check("stream_retired4", 32'(retired_cnt4), 32'd4);

    // Narrow counter wraps after 17 retirements.
    do_reset();
    for (int i = 0; i < 17; i++)
      apply_stimulus(1, 16'($urandom), 4'($urandom), 4'h0, 4'(i), 1, 0);
    apply_stimulus(0, 16'h0, 4'h0, 4'h0, 4'd0, 1, 0);
    check("wrap_retired4", 32'(retired_cnt4), 32'd1);
    check("wrap_retired", 32'(retired_cnt), 32'd17);

    // Reset mid-stream with two buffered entries.
    do_reset();
    apply_stimulus(1, 16'hAAAA, 4'h5, 4'b1000, 4'd1, 0, 0);
    apply_stimulus(1, 16'hBBBB, 4'h6, 4'b0100, 4'd2, 0, 0);
    check("mid_full", 32'(in_ready), 32'd0);
    #2;
    do_reset();
    apply_stimulus(0, 16'h0, 4'h0, 4'h0, 4'd0, 1, 0);
    check("post_reset_valid", 32'(out_valid), 32'd0);

    // Randomized traffic with varying consumer pressure.
    for (int i = 0; i < 3000; i++) begin
      int unsigned pr;
      pr = (i / 500) % 4;
      apply_stimulus($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom), 4'($urandom),
                     4'($urandom), $urandom_range(0, 3) < pr + 1, $urandom_range(0, 15) == 0);
    end
    @(negedge clock);
    check_output();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
